// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter and its
// multi-cycle result FIFO.
package rf_wb_arbiter_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   instr;
   } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Small synchronous FIFO of write-back entries for multi-cycle results.
// Push is ignored when full, pop is ignored when empty.
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  wb_entry_t     din,
   input  logic          pop,
   output wb_entry_t     dout,
   output logic          full,
   output logic [CW-1:0] count
);

   wb_entry_t      mem_q [DEPTH];
   wb_entry_t      mem_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           push_ok, pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// RF write-port arbiter: W-stage has priority, multi-cycle results drain
// from a FIFO in the idle slots; a pending scoreboard feeds decode stall.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int NREG  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_valid,
   input  logic [REG_AW-1:0] w_addr,
   input  logic [XLEN-1:0]   w_data,
   input  logic [XLEN-1:0]   w_pc,
   input  logic [XLEN-1:0]   w_instr,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_addr,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [REG_AW-1:0] mdu_addr,
   input  logic [XLEN-1:0]   mdu_data,
   input  logic [XLEN-1:0]   mdu_pc,
   input  logic [XLEN-1:0]   mdu_instr,
   input  logic [REG_AW-1:0] rd_a1,
   input  logic [REG_AW-1:0] rd_a2,
   output logic              stall,
   output logic              rf_wr,
   output logic [REG_AW-1:0] rf_a3,
   output logic [XLEN-1:0]   rf_wd,
   output logic [XLEN-1:0]   rf_pc,
   output logic [XLEN-1:0]   rf_instr,
   output logic              hazard_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t       fifo_din, fifo_head;
   logic            fifo_push, fifo_pop, fifo_full;
   logic [CW-1:0]   fifo_cnt;
   logic            w_drive;
   logic [NREG-1:0] pend_q, pend_d;
   logic            hazard_err_q, hazard_err_d;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .count (fifo_cnt)
   );

   // Address-0 writes from either source never reach the RF.
   always_comb begin
      mdu_ready = !reset && !fifo_full;
      w_drive   = !reset && w_valid && (w_addr != '0);
      fifo_pop  = !reset && !w_drive && (fifo_cnt != '0);
      fifo_push = mdu_valid && mdu_ready && (mdu_addr != '0);
      fifo_din  = '{addr: mdu_addr, data: mdu_data,
                    pc: mdu_pc, instr: mdu_instr};
      rf_wr     = 1'b0;
      rf_a3     = '0;
      rf_wd     = '0;
      rf_pc     = '0;
      rf_instr  = '0;
      if (w_drive) begin
         rf_wr    = 1'b1;
         rf_a3    = w_addr;
         rf_wd    = w_data;
         rf_pc    = w_pc;
         rf_instr = w_instr;
      end else if (fifo_pop) begin
         rf_wr    = 1'b1;
         rf_a3    = fifo_head.addr;
         rf_wd    = fifo_head.data;
         rf_pc    = fifo_head.pc;
         rf_instr = fifo_head.instr;
      end
   end

   // A new issue to the register being drained keeps it pending.
   always_comb begin
      pend_d = pend_q;
      if (fifo_pop) begin
         pend_d[fifo_head.addr] = 1'b0;
      end
      if (iss_valid && (iss_addr != '0)) begin
         pend_d[iss_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
      hazard_err_d = hazard_err_q || (w_drive && pend_q[w_addr]);
   end

   assign stall = ((rd_a1 != '0) && pend_q[rd_a1]) ||
                  ((rd_a2 != '0) && pend_q[rd_a2]);
   assign hazard_err = hazard_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q       <= '0;
         hazard_err_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         hazard_err_q <= hazard_err_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table for the W-stage path, then a
// queue-based reference model for the multi-cycle drain sequences.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_valid;
   logic [4:0]  w_addr;
   logic [31:0] w_data, w_pc, w_instr;
   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data, mdu_pc, mdu_instr;
   logic [4:0]  rd_a1, rd_a2;
   logic        stall;
   logic        rf_wr;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd, rf_pc, rf_instr;
   logic        hazard_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] m_pend;
   logic        m_haz;

   typedef struct {
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        ewr;
      logic [4:0]  ea;
      logic [31:0] ed;
   } vec_t;

   vec_t vt[6];

   rf_wb_arbiter #(.DEPTH(DEPTH), .NREG(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .w_valid    (w_valid),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .w_pc       (w_pc),
      .w_instr    (w_instr),
      .iss_valid  (iss_valid),
      .iss_addr   (iss_addr),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_addr   (mdu_addr),
      .mdu_data   (mdu_data),
      .mdu_pc     (mdu_pc),
      .mdu_instr  (mdu_instr),
      .rd_a1      (rd_a1),
      .rd_a2      (rd_a2),
      .stall      (stall),
      .rf_wr      (rf_wr),
      .rf_a3      (rf_a3),
      .rf_wd      (rf_wd),
      .rf_pc      (rf_pc),
      .rf_instr   (rf_instr),
      .hazard_err (hazard_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic wv, input logic [4:0] wa,
                        input logic [31:0] wd, input logic iv,
                        input logic [4:0] ia, input logic mv,
                        input logic [4:0] ma, input logic [31:0] md,
                        input logic [4:0] r1);
      w_valid   = wv;
      w_addr    = wa;
      w_data    = wd;
      w_pc      = ~wd;
      w_instr   = wd + 32'd1;
      iss_valid = iv;
      iss_addr  = ia;
      mdu_valid = mv;
      mdu_addr  = ma;
      mdu_data  = md;
      mdu_pc    = ~md;
      mdu_instr = md + 32'd2;
      rd_a1     = r1;
      rd_a2     = 5'd0;
   endtask

   // One clock with current inputs: compare against the model at the
   // falling edge, then advance the model across the rising edge.
   task automatic cycle(input string tag);
      logic w_drv, pop, e_rdy, e_stall;
      ent_t h;
      @(negedge clk);
      w_drv   = w_valid && (w_addr != 5'd0);
      e_rdy   = (sb.size() < DEPTH);
      pop     = !w_drv && (sb.size() > 0);
      e_stall = ((rd_a1 != 0) && m_pend[rd_a1]) ||
                ((rd_a2 != 0) && m_pend[rd_a2]);
      chk({tag, ".rf_wr"}, 32'(rf_wr), 32'(w_drv || pop));
      chk({tag, ".ready"}, 32'(mdu_ready), 32'(e_rdy));
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".hazard"}, 32'(hazard_err), 32'(m_haz));
      if (w_drv) begin
         chk({tag, ".w_a3"}, 32'(rf_a3), 32'(w_addr));
         chk({tag, ".w_wd"}, rf_wd, w_data);
         chk({tag, ".w_pc"}, rf_pc, w_pc);
      end else if (pop) begin
         h = sb.pop_front();
         chk({tag, ".m_a3"}, 32'(rf_a3), 32'(h.a));
         chk({tag, ".m_wd"}, rf_wd, h.d);
         chk({tag, ".m_ins"}, rf_instr, h.ins);
         m_pend[h.a] = 1'b0;
      end
      if (w_drv && m_pend[w_addr] && !(pop)) m_haz = 1'b1;
      if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
      if (mdu_valid && e_rdy && mdu_addr != 0)
         sb.push_back('{mdu_addr, mdu_data, mdu_pc, mdu_instr});
      m_pend[0] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb.delete();
      m_pend = '0;
      m_haz  = 1'b0;
   endtask

   initial begin
      vt[0] = '{1'b1, 5'd8,  32'h12345678, 5'd0, 5'd0, 1'b1, 5'd8,  32'h12345678};
      vt[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd3, 5'd0, 1'b0, 5'd0,  32'h0};
      vt[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd9, 1'b1, 5'd31, 32'hFFFFFFFF};
      vt[3] = '{1'b0, 5'd5,  32'h00000001, 5'd5, 5'd5, 1'b0, 5'd0,  32'h0};
      vt[4] = '{1'b1, 5'd1,  32'h00000000, 5'd1, 5'd2, 1'b1, 5'd1,  32'h0};
      vt[5] = '{1'b1, 5'd16, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1, 5'd16, 32'hA5A5A5A5};

      model_reset();
      drive(1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd3, 32'h1, 5'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst.rf_wr", 32'(rf_wr), 32'd0);
      chk("rst.ready", 32'(mdu_ready), 32'd0);
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.hazard", 32'(hazard_err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("idle");

      foreach (vt[i]) begin
         drive(vt[i].wv, vt[i].wa, vt[i].wd, 1'b0, 5'd0, 1'b0, 5'd0,
               32'h0, vt[i].r1);
         rd_a2 = vt[i].r2;
         @(negedge clk);
         chk($sformatf("vec%0d.wr", i), 32'(rf_wr), 32'(vt[i].ewr));
         chk($sformatf("vec%0d.a3", i), 32'(rf_a3), 32'(vt[i].ea));
         chk($sformatf("vec%0d.wd", i), rf_wd, vt[i].ed);
         chk($sformatf("vec%0d.stall", i), 32'(stall), 32'd0);
         @(posedge clk);
         #1;
      end

      // Issue to r5, stall on read, MDU result drains one cycle later.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("iss5");
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5);
      @(negedge clk);
      chk("iss5.stall_const", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hAAAA0000, 5'd5);
      cycle("mdu5.acc");
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5);
      @(negedge clk);
      chk("mdu5.wr_const", 32'(rf_wr), 32'd1);
      chk("mdu5.wd_const", rf_wd, 32'hAAAA0000);
      chk("mdu5.stall_drain", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      m_pend[5] = 1'b0;
      void'(sb.pop_front());
      cycle("mdu5.after");

      // Two MDU results while W-stage busy, then in-order drain.
      drive(1'b1, 5'd10, 32'h100, 1'b0, 5'd0, 1'b1, 5'd3, 32'h3333, 5'd0);
      cycle("two.a");
      drive(1'b1, 5'd11, 32'h101, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444, 5'd0);
      cycle("two.b");
      drive(1'b1, 5'd12, 32'h102, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9999, 5'd0);
      @(negedge clk);
      chk("two.full_ready", 32'(mdu_ready), 32'd0);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("two.d3");
      cycle("two.d4");
      cycle("two.empty");

      // Full FIFO with mdu_valid held: throughput and ordering.
      drive(1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 1'b1, 5'd20, 32'h2000, 5'd0);
      cycle("full.f0");
      drive(1'b1, 5'd2, 32'h201, 1'b0, 5'd0, 1'b1, 5'd21, 32'h2100, 5'd0);
      cycle("full.f1");
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'(22 + k),
               32'h3000 + 32'(k), 5'd0);
         cycle($sformatf("full.h%0d", k));
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      for (int k = 0; k < 3; k++) cycle($sformatf("full.d%0d", k));
      chk("full.sb_empty", 32'(sb.size()), 32'd0);

      // Set wins over drain-clear on r7, then W-stage hazard.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("haz.iss");
      drive(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 1'b1, 5'd7, 32'h7777, 5'd0);
      cycle("haz.acc");
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("haz.popset");
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7);
      @(negedge clk);
      chk("haz.stall7", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      cycle("haz.wr7");
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      @(negedge clk);
      chk("haz.set", 32'(hazard_err), 32'd1);
      @(posedge clk);
      #1;
      cycle("haz.sticky");

      // Reset with two entries queued.
      drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd12, 1'b1, 5'd12, 32'hC0C0, 5'd0);
      cycle("rq.a");
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 1'b1, 5'd13, 32'hD0D0, 5'd0);
      cycle("rq.b");
      drive(1'b1, 5'd6, 32'h3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rq.rst_wr", 32'(rf_wr), 32'd0);
      chk("rq.rst_ready", 32'(mdu_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd12);
      rd_a2 = 5'd13;
      cycle("rq.post0");
      cycle("rq.post1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sits between the write-back sources and the register file write port; drives the RF write port (addr, data, enable, plus PC/instr for the trace display).
- Merges two producers: the in-order W-stage result (never stalls, always priority) and a multi-cycle unit (MDU / slow load) result delivered over a valid/ready handshake and buffered in a small FIFO.
- Holds a per-register pending scoreboard so decode can stall on reads of registers with an outstanding multi-cycle write.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2)
- NREG, 32, architectural registers; address width is log2(NREG)=5

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- w_valid  in  1  W-stage has a write this cycle
- w_addr  in  5  W-stage destination
- w_data  in  32  W-stage result
- w_pc  in  32  W-stage PC
- w_instr  in  32  W-stage instruction
- iss_valid  in  1  multi-cycle op issued this cycle
- iss_addr  in  5  its destination register
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept
- mdu_addr  in  5  MDU destination
- mdu_data  in  32  MDU result
- mdu_pc  in  32  issuing PC
- mdu_instr  in  32  issuing instruction
- rd_a1  in  5  decode read address 1
- rd_a2  in  5  decode read address 2
- stall  out  1  rd_a1 or rd_a2 is nonzero and pending
- rf_wr  out  1  RF write enable
- rf_a3  out  5  RF write address
- rf_wd  out  32  RF write data
- rf_pc  out  32  PC of the write (trace)
- rf_instr  out  32  instruction of the write (trace)
- hazard_err  out  1  sticky: W-stage wrote a pending register

Behaviour:
- RF write port is combinational from current inputs and FIFO head; zero added latency for W-stage writes.
- Select: if w_valid and w_addr!=0, the W-stage write is driven; else if FIFO not empty, the head entry is driven and popped at the clock edge; else rf_wr=0 and other rf_* outputs are don't-care (driven to 0).
- W-stage writes with w_addr==0 are dropped (rf_wr=0 from that source); the FIFO may drain in that cycle.
- FIFO accepts an entry on mdu_valid && mdu_ready; mdu_ready = (count < DEPTH), registered-state only. Ready stays 0 when full, even if a pop occurs in the same cycle.
- MDU results with addr 0 are accepted but discarded (not enqueued).
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Pending scoreboard (NREG bits):
  - iss_valid with iss_addr!=0 sets the bit.
  - A FIFO pop clears the bit of the popped address.
  - Set and clear of the same register in the same cycle: set wins.
  - Bit 0 is never set.
- stall = (rd_a1!=0 && pending[rd_a1]) || (rd_a2!=0 && pending[rd_a2]); combinational from registered state. There is no bypass from the FIFO head; the RF's own write-through covers the drain cycle.
- hazard_err is set when a driven W-stage write targets a pending register; it holds until reset.
- Reset (any time, including mid-drain):
  - FIFO emptied, count=0, pointers=0; pending cleared; hazard_err=0.
  - rf_wr=0 while reset is high, regardless of w_valid; mdu_ready=0 while reset is high.
  - Entries in flight are lost.

Decomposition:
- Shared package: REG_AW=5, XLEN=32, a wb_entry struct (addr, data, pc, instr) used by the FIFO and by the MDU.
- One sub-module: wb_fifo (parameterised DEPTH synchronous FIFO of wb_entry with push/pop/full/empty/count). Arbitration and scoreboard stay in the top.

Test Plan:
- Reset, then w_valid=1 w_addr=8 w_data=0x12345678 -> same cycle rf_wr=1 rf_a3=8 rf_wd=0x12345678; w_addr=0 -> rf_wr=0.
- iss_valid addr=5; rd_a1=5 next cycle -> stall=1; MDU offers addr=5 data=0xAAAA0000 with w_valid=0 -> written one cycle after acceptance, stall falls the cycle after the pop.
- Two MDU results accepted (addr 3, 4) while w_valid=1 continuously -> mdu_ready=0 after the 2nd; rf_wr shows W-stage only; w_valid drops -> addr 3 then addr 4 written in order on consecutive cycles.
- Full FIFO, W-stage idle, mdu_valid held -> pop each cycle, mdu_ready reasserts the cycle after count<2; no entry lost or duplicated.
- iss_valid addr=7 in the same cycle the FIFO pops addr 7 -> pending[7] remains 1. W-stage writes reg 7 -> hazard_err=1, sticky.
- Assert reset with 2 entries queued -> rf_wr=0, mdu_ready=0; after release count=0, stall=0, no write of the old entries.
